// File: rtl/icache_refill_buffer.sv
// Assembles four 32-bit bus return beats into a 128-bit cache line, optionally
// byte-merging a pending store word, then strobes the line into the data RAM.
module icache_refill_buffer (
   input  logic         clk,
   input  logic         rstn,
   input  logic         refill_start,
   input  logic         store_en,
   input  logic [1:0]   store_offset,
   input  logic [3:0]   store_wstrb,
   input  logic [31:0]  store_wdata,
   input  logic         ret_valid,
   input  logic         ret_last,
   input  logic [31:0]  ret_data,
   output logic         w_en_mem,
   output logic [127:0] w_data_mem,
   output logic         busy,
   output logic         err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [127:0]  line_q, line_d;
   logic          err_q, err_d;
   logic          stEn_q, stEn_d;
   logic [1:0]    stOff_q, stOff_d;
   logic [3:0]    stStrb_q, stStrb_d;
   logic [31:0]   stData_q, stData_d;
   logic [31:0]   beatWord;
   logic          protoViol;

   // Store bytes override the returning word only at the latched word index.
   always_comb begin
      beatWord = ret_data;
      for (int b = 0; b < 4; b++) begin
         if (stEn_q && (cnt_q == stOff_q) && stStrb_q[b]) begin
            beatWord[8*b +: 8] = stData_q[8*b +: 8];
         end
      end
   end

   // The last flag must coincide exactly with the fourth beat.
   assign protoViol = ret_valid && (ret_last != (cnt_q == 2'd3));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      line_d   = line_q;
      err_d    = 1'b0;
      stEn_d   = stEn_q;
      stOff_d  = stOff_q;
      stStrb_d = stStrb_q;
      stData_d = stData_q;
      case (state_q)
         IDLE: begin
            cnt_d    = 2'd0;
            stEn_d   = refill_start & store_en;
            stOff_d  = store_offset;
            stStrb_d = store_wstrb;
            stData_d = store_wdata;
            if (refill_start) begin
               state_d = FILL;
            end
         end
         FILL: begin
            if (protoViol) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (ret_valid) begin
               line_d[{cnt_q, 5'd0} +: 32] = beatWord;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= 2'd0;
         line_q   <= '0;
         err_q    <= 1'b0;
         stEn_q   <= 1'b0;
         stOff_q  <= 2'd0;
         stStrb_q <= 4'd0;
         stData_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         line_q   <= line_d;
         err_q    <= err_d;
         stEn_q   <= stEn_d;
         stOff_q  <= stOff_d;
         stStrb_q <= stStrb_d;
         stData_q <= stData_d;
      end
   end

   assign w_en_mem   = (state_q == WRITE);
   assign busy       = (state_q != IDLE);
   assign err        = err_q;
   assign w_data_mem = line_q;

endmodule

// File: tb/tb_icache_refill_buffer.sv
// Bench for icache_refill_buffer: constant vector table, directed corner
// sequences and random traffic against a queue-based line model.
module tb_icache_refill_buffer;

   logic         clk = 1'b0;
   logic         rstn;
   logic         refill_start;
   logic         store_en;
   logic [1:0]   store_offset;
   logic [3:0]   store_wstrb;
   logic [31:0]  store_wdata;
   logic         ret_valid;
   logic         ret_last;
   logic [31:0]  ret_data;
   logic         w_en_mem;
   logic [127:0] w_data_mem;
   logic         busy;
   logic         err;

   int errors = 0;
   int checks = 0;
   int wenSeen = 0;
   int errSeen = 0;

   // Reference model: a refill is a list of collected words.
   bit          mFilling;
   bit          mWriting;
   bit          mErr;
   logic [31:0] mWords[$];
   bit          mStEn;
   logic [1:0]  mOff;
   logic [3:0]  mStrb;
   logic [31:0] mWdata;
   logic [127:0] mLine;

   typedef struct {
      logic         start;
      logic         sten;
      logic [1:0]   off;
      logic [3:0]   strb;
      logic [31:0]  wdata;
      logic         valid;
      logic         last;
      logic [31:0]  data;
      logic         eWen;
      logic         eBusy;
      logic         eErr;
      logic         chkLine;
      logic [127:0] eLine;
   } vec_t;

   vec_t tbl[12];

   always #5 clk = ~clk;

   icache_refill_buffer dut (
      .clk          (clk),
      .rstn         (rstn),
      .refill_start (refill_start),
      .store_en     (store_en),
      .store_offset (store_offset),
      .store_wstrb  (store_wstrb),
      .store_wdata  (store_wdata),
      .ret_valid    (ret_valid),
      .ret_last     (ret_last),
      .ret_data     (ret_data),
      .w_en_mem     (w_en_mem),
      .w_data_mem   (w_data_mem),
      .busy         (busy),
      .err          (err)
   );

   function automatic vec_t mkVec(logic start, logic sten, logic [1:0] off, logic [3:0] strb,
                                  logic [31:0] wdata, logic valid, logic last, logic [31:0] data,
                                  logic eWen, logic eBusy, logic eErr, logic chkLine,
                                  logic [127:0] eLine);
      vec_t v;
      v.start = start; v.sten = sten; v.off = off; v.strb = strb; v.wdata = wdata;
      v.valid = valid; v.last = last; v.data = data;
      v.eWen = eWen; v.eBusy = eBusy; v.eErr = eErr; v.chkLine = chkLine; v.eLine = eLine;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic start, input logic sten, input logic [1:0] off,
                                input logic [3:0] strb, input logic [31:0] wdata,
                                input logic valid, input logic last, input logic [31:0] data);
      refill_start = start;
      store_en     = sten;
      store_offset = off;
      store_wstrb  = strb;
      store_wdata  = wdata;
      ret_valid    = valid;
      ret_last     = last;
      ret_data     = data;
   endtask

   task automatic idleIn();
      applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic beatIn(input logic last, input logic [31:0] data);
      applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 1'b1, last, data);
   endtask

   task automatic modelReset();
      mFilling = 0; mWriting = 0; mErr = 0;
      mWords.delete();
      mStEn = 0; mOff = 0; mStrb = 0; mWdata = 0;
      mLine = '0;
   endtask

   task automatic modelStep();
      int n;
      logic [31:0] mask;
      logic [31:0] w;
      mErr = 0;
      if (mWriting) begin
         mWriting = 0;
      end else if (mFilling) begin
         if (ret_valid) begin
            n = mWords.size();
            if ((ret_last == 1'b1) != (n == 3)) begin
               mFilling = 0;
               mErr = 1;
            end else begin
               for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{mStrb[b]}};
               w = ret_data;
               if (mStEn && (n == int'(mOff))) w = (mWdata & mask) | (ret_data & ~mask);
               mWords.push_back(w);
               if (n == 3) begin
                  mFilling = 0;
                  mWriting = 1;
                  mLine = {mWords[3], mWords[2], mWords[1], mWords[0]};
               end
            end
         end
      end else if (refill_start) begin
         mFilling = 1;
         mWords.delete();
         mStEn  = store_en;
         mOff   = store_offset;
         mStrb  = store_wstrb;
         mWdata = store_wdata;
      end
   endtask

   // One clock: model advances on the edge, outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("w_en_mem", {127'd0, w_en_mem}, {127'd0, mWriting});
      checkOutput("busy", {127'd0, busy}, {127'd0, (mFilling || mWriting)});
      checkOutput("err", {127'd0, err}, {127'd0, mErr});
      if (mWriting) checkOutput("w_data_mem", w_data_mem, mLine);
      wenSeen += int'(w_en_mem);
      errSeen += int'(err);
   endtask

   task automatic plainRefill(input int gap);
      applyStimulus(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         beatIn(i == 3, 32'h11111111 * (i + 1));
         tick();
         if (i < 3) begin
            for (int g = 0; g < gap; g++) begin
               idleIn();
               tick();
            end
         end
      end
      idleIn();
      tick();
      tick();
   endtask

   localparam logic [127:0] PlainLine = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] MergeLine = 128'h00000000_12BB56DD_00000000_00000000;

   initial begin
      int w0;
      int e0;

      tbl[0]  = mkVec(1, 0, 0, 0, 0, 0, 0, 0,                      0, 1, 0, 0, '0);
      tbl[1]  = mkVec(0, 0, 0, 0, 0, 1, 0, 32'h11111111,           0, 1, 0, 0, '0);
      tbl[2]  = mkVec(1, 1, 3, 4'hF, 32'hDEADBEEF, 1, 0, 32'h22222222, 0, 1, 0, 0, '0);
      tbl[3]  = mkVec(0, 0, 0, 0, 0, 1, 0, 32'h33333333,           0, 1, 0, 0, '0);
      tbl[4]  = mkVec(0, 0, 0, 0, 0, 1, 1, 32'h44444444,           1, 1, 0, 1, PlainLine);
      tbl[5]  = mkVec(1, 0, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 1, PlainLine);
      tbl[6]  = mkVec(1, 1, 2, 4'b0101, 32'hAABBCCDD, 0, 0, 0,     0, 1, 0, 0, '0);
      tbl[7]  = mkVec(0, 0, 0, 0, 0, 1, 0, 32'h00000000,           0, 1, 0, 0, '0);
      tbl[8]  = mkVec(0, 0, 0, 0, 0, 1, 0, 32'h00000000,           0, 1, 0, 0, '0);
      tbl[9]  = mkVec(0, 0, 0, 0, 0, 1, 0, 32'h12345678,           0, 1, 0, 0, '0);
      tbl[10] = mkVec(0, 0, 0, 0, 0, 1, 1, 32'h00000000,           1, 1, 0, 1, MergeLine);
      tbl[11] = mkVec(0, 0, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 1, MergeLine);

      rstn = 1'b0;
      idleIn();
      modelReset();
      #12;
      checkOutput("reset_w_en_mem", {127'd0, w_en_mem}, '0);
      checkOutput("reset_busy", {127'd0, busy}, '0);
      checkOutput("reset_err", {127'd0, err}, '0);
      checkOutput("reset_w_data_mem", w_data_mem, '0);
      @(negedge clk);
      rstn = 1'b1;

      // Plain refill with ignored starts, then a merged refill.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(tbl[i].start, tbl[i].sten, tbl[i].off, tbl[i].strb, tbl[i].wdata,
                       tbl[i].valid, tbl[i].last, tbl[i].data);
         tick();
         checkOutput($sformatf("vec%0d_w_en_mem", i), {127'd0, w_en_mem}, {127'd0, tbl[i].eWen});
         checkOutput($sformatf("vec%0d_busy", i), {127'd0, busy}, {127'd0, tbl[i].eBusy});
         checkOutput($sformatf("vec%0d_err", i), {127'd0, err}, {127'd0, tbl[i].eErr});
         if (tbl[i].chkLine) checkOutput($sformatf("vec%0d_w_data_mem", i), w_data_mem, tbl[i].eLine);
      end

      // Gapped beats produce the same line with a single write.
      w0 = wenSeen; e0 = errSeen;
      plainRefill(3);
      checkOutput("gapped_writes", wenSeen - w0, 1);
      checkOutput("gapped_errs", errSeen - e0, 0);
      checkOutput("gapped_line", w_data_mem, PlainLine);

      // Early last on beat 2, then a clean refill.
      w0 = wenSeen; e0 = errSeen;
      applyStimulus(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      tick();
      beatIn(1'b0, 32'hCAFE0000); tick();
      beatIn(1'b1, 32'hCAFE0001); tick();
      checkOutput("early_err_pulse", {127'd0, err}, 128'd1);
      checkOutput("early_busy_low", {127'd0, busy}, 128'd0);
      idleIn(); tick();
      checkOutput("early_err_single", {127'd0, err}, 128'd0);
      checkOutput("early_no_write", wenSeen - w0, 0);
      plainRefill(0);
      checkOutput("after_early_line", w_data_mem, PlainLine);
      checkOutput("after_early_writes", wenSeen - w0, 1);
      checkOutput("after_early_errs", errSeen - e0, 1);

      // Missing last on the fourth beat.
      w0 = wenSeen; e0 = errSeen;
      applyStimulus(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         beatIn(1'b0, 32'h0BAD0000 + i);
         tick();
      end
      idleIn(); tick(); tick();
      checkOutput("missing_last_errs", errSeen - e0, 1);
      checkOutput("missing_last_writes", wenSeen - w0, 0);

      // Reset after the first beat abandons the refill.
      w0 = wenSeen;
      applyStimulus(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      tick();
      beatIn(1'b0, 32'h77777777); tick();
      idleIn();
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("midreset_busy", {127'd0, busy}, '0);
      checkOutput("midreset_w_en_mem", {127'd0, w_en_mem}, '0);
      checkOutput("midreset_err", {127'd0, err}, '0);
      checkOutput("midreset_w_data_mem", w_data_mem, '0);
      @(posedge clk);
      #1;
      checkOutput("midreset_held_w_en_mem", {127'd0, w_en_mem}, '0);
      @(negedge clk);
      rstn = 1'b1;
      modelReset();
      idleIn(); tick(); tick();
      checkOutput("midreset_no_write", wenSeen - w0, 0);
      plainRefill(0);
      checkOutput("after_reset_line", w_data_mem, PlainLine);
      checkOutput("after_reset_writes", wenSeen - w0, 1);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         logic lastBit;
         lastBit = (mWords.size() == 3);
         if ($urandom_range(0, 19) == 0) lastBit = ~lastBit;
         applyStimulus(($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                       2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
                       ($urandom_range(0, 9) < 6), lastBit, $urandom);
         tick();
      end

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
